log_lane_ctrl: RTL

//  Owns one river lane of scrolling logs: keeps NUM_LOGS horizontal positions, advances them on frame ticks

---
 rtl/log_lane_ctrl_if.sv | 36 +++
 rtl/log_lane_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/log_lane_ctrl_if.sv
// Bundle between one log lane controller and its surroundings: the frame/scan
// inputs, the sprite ROM address/data pair, and the pixel and ride outputs.
//   frame_tick  one-cycle pulse per frame (vblank start)
//   enable      0 freezes motion; lookup still works
//   DrawX/DrawY current scan column/row
//   rom_data    palette index from the sprite ROM, combinational from DX/DY
//   DX/DY/dir   sprite ROM address and orientation
//   pixel_idx   palette index for this pixel, 0 = transparent/no log
//   pixel_hit   opaque log pixel present
//   ride_step   one-cycle pulse the cycle after the logs moved
//   ride_delta  signed pixels applied per step
// Modports: slave = the lane controller, master = whoever drives scan/ROM.
interface log_lane_ctrl_if;
  logic       frame_tick;
  logic       enable;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [7:0] rom_data;
  logic [5:0] DX;
  logic [5:0] DY;
  logic       dir;
  logic [7:0] pixel_idx;
  logic       pixel_hit;
  logic       ride_step;
  logic [3:0] ride_delta;

  modport slave (
    input  frame_tick, enable, DrawX, DrawY, rom_data,
    output DX, DY, dir, pixel_idx, pixel_hit, ride_step, ride_delta
  );

  modport master (
    output frame_tick, enable, DrawX, DrawY, rom_data,
    input  DX, DY, dir, pixel_idx, pixel_hit, ride_step, ride_delta
  );
endinterface

// File: rtl/log_lane_ctrl.sv
// One river lane of scrolling logs. Holds NUM_LOGS right-edge positions in a
// virtual strip SCREEN_W+SPR_W wide, moves them every FRAMES_PER_STEP enabled
// frame ticks with wrap-around, and runs a two-stage lookup per scanned pixel:
// stage 1 registers the sprite ROM address, stage 2 registers the palette index.
// Ports:
//   Clk    pixel-domain clock
//   Reset  asynchronous, active-high
//   bus    log_lane_ctrl_if.slave (scan inputs, ROM address/data, pixel/ride outputs)
module log_lane_ctrl #(
  parameter int unsigned NUM_LOGS        = 3,
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SPR_W           = 48,
  parameter int unsigned SPR_H           = 24,
  parameter int unsigned LANE_Y          = 96,
  parameter int unsigned SPACING         = 224,
  parameter int unsigned SPEED           = 2,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned DIR             = 0
) (
  input logic            Clk,
  input logic            Reset,
  log_lane_ctrl_if.slave bus
);

  localparam int unsigned VW = SCREEN_W + SPR_W;

  localparam logic [10:0] Vw       = 11'(VW);
  localparam logic [10:0] Spd      = 11'(SPEED);
  localparam logic [11:0] SprW     = 12'(SPR_W);
  localparam logic [9:0]  LaneTop  = 10'(LANE_Y);
  localparam logic [9:0]  LaneBot  = 10'(LANE_Y + SPR_H);
  localparam logic [3:0]  StepLast = 4'(FRAMES_PER_STEP - 1);
  // Two's complement of SPEED when moving left.
  localparam logic [3:0]  Delta    = (DIR != 0) ? 4'(SPEED) : 4'(16 - SPEED);

  logic [10:0] log_x_q [NUM_LOGS];
  logic [10:0] log_x_d [NUM_LOGS];
  logic [11:0] off     [NUM_LOGS];
  logic [NUM_LOGS-1:0] hit_vec;

  logic [3:0] step_cnt_q;
  logic       hit1_q;
  logic       in_lane;
  logic       any_hit;
  logic [5:0] dx_win;
  logic       tick_en;
  logic       move;

  assign bus.dir        = (DIR != 0);
  assign bus.ride_delta = Delta;

  assign tick_en = bus.frame_tick && bus.enable;
  assign move    = tick_en && (step_cnt_q == StepLast);

  // Stage 1 hit detection. The offset is kept 12 bits wide so that a column left
  // of the log wraps to a large unsigned value and fails the < SPR_W test.
  always_comb begin
    in_lane = (bus.DrawY >= LaneTop) && (bus.DrawY < LaneBot);
    any_hit = 1'b0;
    dx_win  = '0;
    for (int i = 0; i < NUM_LOGS; i++) begin
      off[i]     = {2'b00, bus.DrawX} + SprW - {1'b0, log_x_q[i]};
      hit_vec[i] = in_lane && (off[i] < SprW);
    end
    // Scan downwards so the lowest-numbered hitting log wins.
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        dx_win  = off[i][5:0];
      end
    end
  end

  // Next positions if a step is taken this cycle, wrapping within [0, VW).
  always_comb begin
    for (int i = 0; i < NUM_LOGS; i++) begin
      if (DIR != 0) begin
        log_x_d[i] = (log_x_q[i] + Spd >= Vw) ? log_x_q[i] + Spd - Vw : log_x_q[i] + Spd;
      end else begin
        log_x_d[i] = (log_x_q[i] < Spd) ? log_x_q[i] + Vw - Spd : log_x_q[i] - Spd;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_LOGS; i++) begin
        log_x_q[i] <= 11'(i * SPACING);
      end
      step_cnt_q    <= '0;
      hit1_q        <= 1'b0;
      bus.DX        <= '0;
      bus.DY        <= '0;
      bus.pixel_idx <= '0;
      bus.pixel_hit <= 1'b0;
      bus.ride_step <= 1'b0;
    end else begin
      // Motion
      bus.ride_step <= move;
      if (tick_en) begin
        if (step_cnt_q == StepLast) begin
          step_cnt_q <= '0;
          log_x_q    <= log_x_d;
        end else begin
          step_cnt_q <= step_cnt_q + 4'd1;
        end
      end

      // Lookup stage 1: ROM address holds its last value on a miss.
      hit1_q <= any_hit;
      if (any_hit) begin
        bus.DX <= dx_win;
        bus.DY <= 6'(bus.DrawY - LaneTop);
      end

      // Lookup stage 2
      bus.pixel_idx <= hit1_q ? bus.rom_data : 8'd0;
      bus.pixel_hit <= hit1_q && (bus.rom_data != 8'd0);
    end
  end

endmodule
